clk_div_ctrl: RTL and testbench

Multi-channel clock-divider controller and scheduler. It owns N_CH divided-clock channels that share one configuration port. Each channel produces a square wave and a one-cycle toggle strobe from clk_in, with a half-period programmable at run time. Rate changes are deferred to the end of a full output period, so no channel ever emits a truncated or runt pulse. It sits between the control logic (the config writer) and the peripherals that need slow clocks or enables (VGA pixel enables, display refresh, debouncers).

---
 rtl/clk_div_ctrl_if.sv | 26 ++
 rtl/clk_div_ctrl.sv | 119 +++++++++++
 tb/tb_clk_div_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Configuration port of the clock-divider controller: one write per cycle,
// valid/ready handshake, channel select plus half-period value.
interface clk_div_ctrl_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_half;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_half,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Multi-channel clock divider. Each channel makes a 50% square wave plus a
// one-cycle strobe after every toggle. Rate changes wait for the end of a
// full output period (falling edge) so no runt pulse is ever produced.
module clk_div_ctrl #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    clk_div_ctrl_if.slave    cfg,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  active,
    output logic [N_CH-1:0]  pending
);
    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_PEND
    } ch_state_t;

    logic [N_CH-1:0] sel;

    // Selects outside 0..N_CH-1 match no channel, so they read ready and drop
    always_comb begin
        cfg.cfg_ready = ~|(sel & pending);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] half_q, half_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr;
        logic             at_end;
        logic             boundary;
        logic [DIV_W-1:0] apply_val;

        assign sel[g] = (cfg.cfg_ch == CH_W'(g));
        assign wr     = cfg.cfg_valid & cfg.cfg_ready & sel[g];

        // Next-state and counter/output computation for one channel
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            half_d    = half_q;
            pend_d    = pend_q;
            clk_d     = clk_q;
            tick_d    = 1'b0;
            at_end    = (cnt_q == half_q - DIV_W'(1));
            boundary  = at_end & clk_q;
            apply_val = (state_q == ST_PEND) ? pend_q : cfg.cfg_half;

            unique case (state_q)
                ST_OFF: begin
                    if (wr && (cfg.cfg_half != '0)) begin
                        half_d  = cfg.cfg_half;
                        cnt_d   = '0;
                        clk_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_PEND: begin
                    // A write arriving exactly on the falling-edge boundary
                    // takes the same apply path as a held pending value
                    if (boundary && ((state_q == ST_PEND) || wr)) begin
                        clk_d   = 1'b0;
                        tick_d  = 1'b1;
                        cnt_d   = '0;
                        half_d  = apply_val;
                        state_d = (apply_val != '0) ? ST_RUN : ST_OFF;
                    end else begin
                        if (at_end) begin
                            cnt_d  = '0;
                            clk_d  = ~clk_q;
                            tick_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + DIV_W'(1);
                        end
                        if (wr) begin
                            pend_d  = cfg.cfg_half;
                            state_d = ST_PEND;
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        // Channel state register with asynchronous active-low reset
        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
                half_q  <= '0;
                pend_q  <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                half_q  <= half_d;
                pend_q  <= pend_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
        assign active[g]  = (state_q != ST_OFF);
        assign pending[g] = (state_q == ST_PEND);
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: traces per-channel outputs sample by sample
// after a write and compares them against hand-derived bit patterns.
module tb_clk_div_ctrl;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned DIV_W = 16;

    logic            clk_in = 1'b0;
    logic            reset  = 1'b0;
    logic [N_CH-1:0] clk_out, tick, active, pending;

    clk_div_ctrl_if #(.N_CH(N_CH), .DIV_W(DIV_W)) cfg_if ();

    clk_div_ctrl #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .cfg     (cfg_if),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active),
        .pending (pending)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] tr_clk, tr_tick, tr_act, tr_pend;
    logic [3:0]  others;
    logic        ready_before;
    int          acc_k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        cfg_if.cfg_valid = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    // Present one write for the next edge; returns just after that edge (k=0)
    task automatic write_now(input int ch, input int half);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_half  = 16'(half);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic record(input int k, input int ch);
        tr_clk[k]  = clk_out[ch];
        tr_tick[k] = tick[ch];
        tr_act[k]  = active[ch];
        tr_pend[k] = pending[ch];
    endtask

    task automatic clear_trace();
        tr_clk = '0; tr_tick = '0; tr_act = '0; tr_pend = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_half  = '0;

        // Reset state
        repeat (2) step();
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick",    32'(tick),    32'h0);
        check("rst_active",  32'(active),  32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_ready",   32'(cfg_if.cfg_ready), 32'h1);
        reset = 1'b1;
        step();

        // 1: ch0 half=2 from OFF
        clear_trace();
        others = '0;
        write_now(0, 2);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            record(k, 0);
            others = others | {1'b0, clk_out[3:1] | tick[3:1] | active[3:1]};
        end
        check("t1_clk0",   tr_clk[7:0],  32'hCC);
        check("t1_tick0",  tr_tick[7:0], 32'h54);
        check("t1_act0",   tr_act[7:0],  32'hFF);
        check("t1_others", 32'(others),  32'h0);

        // 2: ch1 half=3, retime to 5 mid-period, second write stalls until apply
        do_reset();
        clear_trace();
        acc_k = 0;
        write_now(1, 3);
        record(0, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            record(k, 1);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_half  = 16'd5;
        step();
        record(4, 1);
        check("t2_ready_k4", 32'(cfg_if.cfg_ready), 32'h0);
        cfg_if.cfg_half = 16'd2;
        for (int k = 5; k <= 20; k++) begin
            ready_before = cfg_if.cfg_ready;
            if (k == 5) check("t2_ready_k5", 32'(ready_before), 32'h0);
            step();
            record(k, 1);
            if (cfg_if.cfg_valid && ready_before && acc_k == 0) begin
                acc_k = k;
                cfg_if.cfg_valid = 1'b0;
            end
        end
        cfg_if.cfg_valid = 1'b0;
        check("t2_accept_edge", 32'(acc_k), 32'd7);
        check("t2_clk1",  tr_clk[20:0],  32'(21'b0_1100_1111_1000_0011_1000));
        check("t2_tick1", tr_tick[20:0], 32'(21'b1_0101_0000_1000_0100_1000));
        check("t2_pend1", tr_pend[20:0], 32'(21'b0_0000_1111_1111_1011_0000));
        cfg_if.cfg_ch = 2'd0;
        #0 check("t2_ready_other_ch", 32'(cfg_if.cfg_ready), 32'h1);

        // 3: ch2 half=4, stop request before the first rise
        do_reset();
        clear_trace();
        write_now(2, 4);
        record(0, 2);
        step();
        record(1, 2);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd2;
        cfg_if.cfg_half  = 16'd0;
        step();
        record(2, 2);
        cfg_if.cfg_valid = 1'b0;
        for (int k = 3; k < 16; k++) begin
            step();
            record(k, 2);
        end
        check("t3_clk2",  tr_clk[15:0],  32'h00F0);
        check("t3_tick2", tr_tick[15:0], 32'h0110);
        check("t3_act2",  tr_act[15:0],  32'h00FF);
        check("t3_pend2", tr_pend[15:0], 32'h00FC);

        // 4: write lands on the falling-edge boundary of ch0
        do_reset();
        clear_trace();
        write_now(0, 2);
        record(0, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            record(k, 0);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_half  = 16'd3;
        step();
        record(4, 0);
        cfg_if.cfg_valid = 1'b0;
        for (int k = 5; k <= 12; k++) begin
            step();
            record(k, 0);
        end
        check("t4_clk0",  tr_clk[12:0],  32'(13'b0_0011_1000_1100));
        check("t4_tick0", tr_tick[12:0], 32'(13'b0_0100_1001_0100));
        check("t4_pend0", tr_pend[12:0], 32'h0);

        // 5: ch0 half=2 then ch3 half=1 on the next cycle
        do_reset();
        clear_trace();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_half  = 16'd2;
        step();
        tr_clk[0] = clk_out[0]; tr_act[0] = clk_out[3]; tr_tick[0] = tick[3];
        cfg_if.cfg_ch    = 2'd3;
        cfg_if.cfg_half  = 16'd1;
        for (int k = 1; k < 12; k++) begin
            step();
            if (k == 1) cfg_if.cfg_valid = 1'b0;
            tr_clk[k]  = clk_out[0];
            tr_act[k]  = clk_out[3];
            tr_tick[k] = tick[3];
        end
        check("t5_clk0",  tr_clk[11:0],  32'hCCC);
        check("t5_clk3",  tr_act[11:0],  32'h554);
        check("t5_tick3", tr_tick[11:0], 32'hFFC);

        // 6: all channels running, ch1 pending, asynchronous reset mid-cycle
        write_now(1, 3);
        write_now(2, 4);
        write_now(1, 7);
        check("t6_active_pre",  32'(active),  32'hF);
        check("t6_pending_pre", 32'(pending), 32'h2);
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_clk_out", 32'(clk_out), 32'h0);
        check("t6_rst_tick",    32'(tick),    32'h0);
        check("t6_rst_active",  32'(active),  32'h0);
        check("t6_rst_pending", 32'(pending), 32'h0);
        step();
        reset = 1'b1;
        others = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            others = others | clk_out | tick | active | pending;
        end
        check("t6_stays_off", 32'(others), 32'h0);
        cfg_if.cfg_ch = 2'd1;
        #0 check("t6_ready_after", 32'(cfg_if.cfg_ready), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
